// File: rtl/ps2_keyboard_decoder_pkg.sv
// ps2_keyboard_decoder_pkg
//   Shared constants for the PS/2 keyboard receive path: scan-code prefix
//   bytes, frame length and the default timing parameters.
package ps2_keyboard_decoder_pkg;

   localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;  // extended-key prefix
   localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;  // key-release prefix

   localparam int FRAME_BITS = 11;                  // start, 8 data, parity, stop

   localparam int DEF_SAMPLE_DIV    = 128;          // CLK cycles per sample tick
   localparam int DEF_FILTER_LEN    = 8;            // equal samples to accept a level
   localparam int DEF_TIMEOUT_TICKS = 256;          // ticks before a partial frame is dropped

endpackage

// File: rtl/ps2_keyboard_decoder_sample_tick.sv
// ps2_sample_tick
//   Free-running divider producing a one-CLK-cycle enable every
//   SAMPLE_DIV cycles; paces the PS2_CLK filter and the timeout counter.
// Ports:
//   CLK    system clock
//   reset  asynchronous, active-low reset
//   tick   one-cycle pulse when the divider wraps
module ps2_sample_tick #(
   parameter int SAMPLE_DIV = 128
) (
   input  logic CLK,
   input  logic reset,
   output logic tick
);

   localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   logic [CW-1:0] div_cnt;

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         div_cnt <= '0;
         tick    <= 1'b0;
      end else begin
         tick <= (div_cnt == CW'(SAMPLE_DIV - 1));
         if (div_cnt == CW'(SAMPLE_DIV - 1)) div_cnt <= '0;
         else                                div_cnt <= div_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/ps2_keyboard_decoder.sv
// ps2_keyboard_decoder
//   Receive-only PS/2 keyboard front end. Filters PS2_CLK, samples PS2_DAT on
//   filtered falling edges, checks 11-bit frames and tracks up to two held
//   keys from make/break scan-code sequences.
// Ports:
//   CLK         system clock
//   reset       asynchronous, active-low reset
//   PS2_CLK     keyboard clock line (asynchronous)
//   PS2_DAT     keyboard data line, never driven by this block
//   scandata    last valid received byte
//   scan_valid  one-cycle pulse when scandata updates
//   frame_err   one-cycle pulse on start/parity/stop error
//   key1_on/key1_code, key2_on/key2_code   held-key slots
module ps2_keyboard_decoder
   import ps2_keyboard_decoder_pkg::*;
#(
   parameter int SAMPLE_DIV    = DEF_SAMPLE_DIV,
   parameter int FILTER_LEN    = DEF_FILTER_LEN,
   parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       PS2_CLK,
   inout  wire        PS2_DAT,
   output logic [7:0] scandata,
   output logic       scan_valid,
   output logic       frame_err,
   output logic       key1_on,
   output logic       key2_on,
   output logic [7:0] key1_code,
   output logic [7:0] key2_code
);

   localparam int TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

   // Host never transmits.
   assign PS2_DAT = 1'bz;

   logic tick;

   ps2_sample_tick #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
      .CLK   (CLK),
      .reset (reset),
      .tick  (tick)
   );

   // ---------------- synchronisers ----------------
   logic [1:0] clk_sync, dat_sync;
   logic       clk_s, dat_s;

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         clk_sync <= '0;
         dat_sync <= '0;
      end else begin
         clk_sync <= {clk_sync[0], PS2_CLK};
         dat_sync <= {dat_sync[0], PS2_DAT};
      end
   end

   assign clk_s = clk_sync[1];
   assign dat_s = dat_sync[1];

   // ---------------- clock filter ----------------
   // Level changes only once FILTER_LEN consecutive ticks agree, so short
   // glitches on PS2_CLK never produce an edge.
   logic [FILTER_LEN-1:0] hist, hist_nxt;
   logic                  clk_f, clk_f_q, fall;

   assign hist_nxt = {hist[FILTER_LEN-2:0], clk_s};

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         hist    <= '0;
         clk_f   <= 1'b0;
         clk_f_q <= 1'b0;
      end else begin
         clk_f_q <= clk_f;
         if (tick) begin
            hist <= hist_nxt;
            if (&hist_nxt)       clk_f <= 1'b1;
            else if (~|hist_nxt) clk_f <= 1'b0;
         end
      end
   end

   assign fall = clk_f_q & ~clk_f;

   // ---------------- frame receiver ----------------
   // After ten bits shreg holds {parity, D7..D0, start}; the stop bit is
   // still on dat_s when the eleventh edge arrives.
   logic [3:0]    bit_cnt;
   logic [9:0]    shreg;
   logic [TW-1:0] tmo_cnt;
   logic          frame_ok;

   assign frame_ok = ~shreg[0] & dat_s & (^shreg[9:1]);

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         bit_cnt    <= '0;
         shreg      <= '0;
         tmo_cnt    <= '0;
         scandata   <= '0;
         scan_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         scan_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (fall) begin
            tmo_cnt <= '0;
            if (bit_cnt == 4'(FRAME_BITS - 1)) begin
               bit_cnt <= '0;
               if (frame_ok) begin
                  scandata   <= shreg[8:1];
                  scan_valid <= 1'b1;
               end else begin
                  frame_err  <= 1'b1;
               end
            end else begin
               shreg   <= {dat_s, shreg[9:1]};
               bit_cnt <= bit_cnt + 4'd1;
            end
         end else if (tick && bit_cnt != '0) begin
            // Stalled mid-frame: drop it silently so the next start bit resyncs.
            if (tmo_cnt == TW'(TIMEOUT_TICKS - 1)) begin
               bit_cnt <= '0;
               tmo_cnt <= '0;
            end else begin
               tmo_cnt <= tmo_cnt + TW'(1);
            end
         end
      end
   end

   // ---------------- key-slot tracker ----------------
   logic ext_flg, brk_flg;
   logic hit1, hit2;

   assign hit1 = key1_on && (key1_code == scandata);
   assign hit2 = key2_on && (key2_code == scandata);

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         ext_flg   <= 1'b0;
         brk_flg   <= 1'b0;
         key1_on   <= 1'b0;
         key2_on   <= 1'b0;
         key1_code <= '0;
         key2_code <= '0;
      end else if (scan_valid) begin
         if (scandata == PS2_PREFIX_EXT) begin
            ext_flg <= 1'b1;
         end else if (scandata == PS2_PREFIX_BRK) begin
            brk_flg <= 1'b1;
         end else begin
            if (brk_flg) begin
               // Release clears the flag only; the code stays for readback.
               if (hit1) key1_on <= 1'b0;
               if (hit2) key2_on <= 1'b0;
            end else if (!(hit1 || hit2)) begin
               // Held keys repeat typematically; only a new key takes a slot.
               if (!key1_on) begin
                  key1_on   <= 1'b1;
                  key1_code <= scandata;
               end else if (!key2_on) begin
                  key2_on   <= 1'b1;
                  key2_code <= scandata;
               end
            end
            // Extended keys fold onto their base code, so ext only marks the
            // prefix as consumed.
            if (ext_flg | brk_flg) begin
               ext_flg <= 1'b0;
               brk_flg <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
module tb_ps2_keyboard_decoder;

   localparam int SDIV = 4;
   localparam int FLEN = 4;
   localparam int TMO  = 32;
   localparam int HP   = 40;   // PS2_CLK half-period in CLK cycles (10 ticks)

   logic       CLK = 1'b0;
   logic       reset = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       dat_drv = 1'b1;
   wire        ps2_dat;
   logic [7:0] scandata, key1_code, key2_code;
   logic       scan_valid, frame_err, key1_on, key2_on;

   assign ps2_dat = dat_drv;

   always #5 CLK = ~CLK;

   ps2_keyboard_decoder #(
      .SAMPLE_DIV(SDIV), .FILTER_LEN(FLEN), .TIMEOUT_TICKS(TMO)
   ) dut (
      .CLK        (CLK),
      .reset      (reset),
      .PS2_CLK    (ps2_clk),
      .PS2_DAT    (ps2_dat),
      .scandata   (scandata),
      .scan_valid (scan_valid),
      .frame_err  (frame_err),
      .key1_on    (key1_on),
      .key2_on    (key2_on),
      .key1_code  (key1_code),
      .key2_code  (key2_code)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // pulse monitor
   int   sv_cnt = 0;
   int   fe_cnt = 0;
   logic pend = 1'b0;
   logic lat_during = 1'b0;
   logic lat_after  = 1'b0;

   always @(negedge CLK) begin
      if (scan_valid) begin
         sv_cnt++;
         pend = 1'b1;
         lat_during = key1_on;
      end else if (pend) begin
         pend = 1'b0;
         lat_after = key1_on;
      end
      if (frame_err) fe_cnt++;
   end

   wire [25:0] dut_vec = {key1_on, key2_on, key1_code, key2_code, scandata};

   // ---------------- reference model ----------------
   logic       m_on   [2];
   logic [7:0] m_code [2];
   logic [7:0] m_scan;
   logic       m_brk;

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         m_on[s] = 1'b0;
         m_code[s] = 8'h00;
      end
      m_scan = 8'h00;
      m_brk  = 1'b0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic held;
      m_scan = b;
      if (b == 8'hE0) return;
      if (b == 8'hF0) begin
         m_brk = 1'b1;
         return;
      end
      if (m_brk) begin
         for (int s = 0; s < 2; s++)
            if (m_on[s] && m_code[s] == b) m_on[s] = 1'b0;
      end else begin
         held = 1'b0;
         for (int s = 0; s < 2; s++)
            if (m_on[s] && m_code[s] == b) held = 1'b1;
         if (!held) begin
            for (int s = 0; s < 2; s++) begin
               if (!m_on[s]) begin
                  m_on[s] = 1'b1;
                  m_code[s] = b;
                  break;
               end
            end
         end
      end
      m_brk = 1'b0;
   endtask

   function automatic logic [25:0] exp_vec();
      return {m_on[0], m_on[1], m_code[0], m_code[1], m_scan};
   endfunction

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge CLK);
   endtask

   // err: 0 good, 1 parity, 2 stop, 3 start. gbit: bit index that gets a
   // short low glitch in its high phase (-1 for none).
   task automatic send_frame(input logic [7:0] b, input int err, input int nbits, input int gbit);
      logic [10:0] f;
      f = {(err == 2) ? 1'b0 : 1'b1, (err == 1) ? (^b) : ~(^b), b, (err == 3) ? 1'b1 : 1'b0};
      for (int i = 0; i < nbits; i++) begin
         dat_drv = f[i];
         if (i == gbit) begin
            cyc(8); ps2_clk = 1'b0; cyc(3); ps2_clk = 1'b1; cyc(9);
         end else begin
            cyc(HP / 2);
         end
         ps2_clk = 1'b0;
         cyc(HP);
         ps2_clk = 1'b1;
         cyc(HP / 2);
      end
      dat_drv = 1'b1;
      cyc(HP);
   endtask

   task automatic send_ok(input logic [7:0] b, input int gbit);
      send_frame(b, 0, 11, gbit);
      model_byte(b);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      model_reset();
      cyc(5);
      n_tests++;
      if ({dut_vec, scan_valid, frame_err} !== 28'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h want 0", {dut_vec, scan_valid, frame_err});
      end
      reset = 1'b1;
      cyc(2000);
      n_tests++;
      if (sv_cnt !== 0 || fe_cnt !== 0 || dut_vec !== 26'd0) begin
         n_fail++;
         $display("FAIL idle_quiet: sv=%0d fe=%0d vec=%h want 0 0 0", sv_cnt, fe_cnt, dut_vec);
      end
   endtask

   task automatic test_make();
      int sv0;
      sv0 = sv_cnt;
      send_ok(8'h16, -1);
      n_tests++;
      if (sv_cnt - sv0 !== 1 || scandata !== 8'h16) begin
         n_fail++;
         $display("FAIL make_16_scan: pulses=%0d data=%h want 1 16", sv_cnt - sv0, scandata);
      end
      n_tests++;
      if (lat_during !== 1'b0 || lat_after !== 1'b1) begin
         n_fail++;
         $display("FAIL make_latency: during=%b after=%b want 0 1", lat_during, lat_after);
      end
      n_tests++;
      if (dut_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL make_16_slots: got %h want %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_two_keys();
      send_ok(8'h1E, -1);
      n_tests++;
      if (dut_vec !== exp_vec() || key2_code !== 8'h1E || key2_on !== 1'b1) begin
         n_fail++;
         $display("FAIL second_key: got %h want %h", dut_vec, exp_vec());
      end
      send_ok(8'hF0, -1);
      send_ok(8'h16, -1);
      n_tests++;
      if (dut_vec !== exp_vec() || key1_on !== 1'b0 || key1_code !== 8'h16) begin
         n_fail++;
         $display("FAIL break_16: got %h want %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_repeat_ext();
      send_ok(8'h1E, -1);
      n_tests++;
      if (dut_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL typematic: got %h want %h", dut_vec, exp_vec());
      end
      send_ok(8'hE0, -1);
      send_ok(8'h14, -1);
      n_tests++;
      if (dut_vec !== exp_vec() || key1_code !== 8'h14) begin
         n_fail++;
         $display("FAIL ext_14_slot1: got %h want %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_errors();
      int sv0, fe0;
      for (int e = 1; e <= 3; e++) begin
         sv0 = sv_cnt;
         fe0 = fe_cnt;
         send_frame(8'h45, e, 11, -1);
         n_tests++;
         if (fe_cnt - fe0 !== 1 || sv_cnt - sv0 !== 0 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL frame_err_%0d: fe=%0d sv=%0d vec=%h want 1 0 %h",
                     e, fe_cnt - fe0, sv_cnt - sv0, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_timeout();
      int sv0, fe0;
      sv0 = sv_cnt;
      fe0 = fe_cnt;
      send_frame(8'h5A, 0, 5, -1);
      cyc(400);
      send_ok(8'h76, -1);
      n_tests++;
      if (sv_cnt - sv0 !== 1 || fe_cnt - fe0 !== 0 || dut_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL timeout_76: sv=%0d fe=%0d vec=%h want 1 0 %h",
                  sv_cnt - sv0, fe_cnt - fe0, dut_vec, exp_vec());
      end
   endtask

   task automatic test_glitch();
      int sv0;
      sv0 = sv_cnt;
      send_ok(8'hF0, 3);
      send_ok(8'h14, 6);
      send_ok(8'h26, 8);
      n_tests++;
      if (sv_cnt - sv0 !== 3 || dut_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL glitch: sv=%0d vec=%h want 3 %h", sv_cnt - sv0, dut_vec, exp_vec());
      end
   endtask

   task automatic test_reset_mid();
      send_frame(8'h33, 0, 6, -1);
      reset = 1'b0;
      model_reset();
      #1;
      n_tests++;
      if ({dut_vec, scan_valid, frame_err} !== 28'd0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: got %h want 0", {dut_vec, scan_valid, frame_err});
      end
      ps2_clk = 1'b1;
      dat_drv = 1'b1;
      cyc(10);
      reset = 1'b1;
      cyc(100);
      send_ok(8'h1C, -1);
      n_tests++;
      if (dut_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_mid_recover: got %h want %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_random();
      logic [7:0] pool [8];
      logic [7:0] b;
      int         err, sv0, fe0;
      pool = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'hF0, 8'hF0, 8'hE0, 8'h14};
      for (int i = 0; i < 20; i++) begin
         b   = pool[$urandom_range(0, 7)];
         err = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
         sv0 = sv_cnt;
         fe0 = fe_cnt;
         send_frame(b, err, 11, -1);
         if (err == 0) model_byte(b);
         n_tests++;
         if (dut_vec !== exp_vec() || sv_cnt - sv0 !== (err == 0 ? 1 : 0) ||
             fe_cnt - fe0 !== (err == 0 ? 0 : 1)) begin
            n_fail++;
            $display("FAIL random_%0d byte %h err %0d: vec=%h sv=%0d fe=%0d want %h",
                     i, b, err, dut_vec, sv_cnt - sv0, fe_cnt - fe0, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_make();
      test_two_keys();
      test_repeat_ext();
      test_errors();
      test_timeout();
      test_glitch();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
